score_display: RTL

Time-multiplexed driver for the four-digit seven-segment display. It consumes the two 4-bit player scores produced by the ping-pong game FSM and shows each as a two-digit decimal value: player 0 on the left pair, player 1 on the right pair. It sits between the game core and the board's `seg`/`an` pins. It adds a frame-synchronous score latch, a ghosting guard and win-blink behaviour.

---
 rtl/pingpong_disp_pkg.sv | 24 ++
 rtl/seg7_encode.sv | 29 ++
 rtl/score_display.sv | 74 +++++++
 3 files changed

// File: rtl/pingpong_disp_pkg.sv
// pingpong_disp_pkg: shared constants and types for the score display
//   idx_t      - digit slot index (0 = leftmost)
//   SEG_*      - active-low g..a segment codes
//   AN_PAT     - active-low anode pattern per slot
//   WIN_SCORE  - score that triggers win blink
package pingpong_disp_pkg;
    typedef logic [1:0] idx_t;

    localparam logic [3:0] WIN_SCORE = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: decimal digit to active-low seven-segment pattern
//   digit - value 0..9 (10..15 render blank)
//   blank - force all segments off
//   seg   - g..a, active low
module seg7_encode
    import pingpong_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank)
            case (digit)
                4'd0: seg = SEG_0;
                4'd1: seg = SEG_1;
                4'd2: seg = SEG_2;
                4'd3: seg = SEG_3;
                4'd4: seg = SEG_4;
                4'd5: seg = SEG_5;
                4'd6: seg = SEG_6;
                4'd7: seg = SEG_7;
                4'd8: seg = SEG_8;
                4'd9: seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
    end
endmodule

// File: rtl/score_display.sv
// score_display: multiplexed 4-digit driver for two 0..15 player scores
//   clk, reset - clock, asynchronous active-high reset
//   sc0, sc1   - player scores, latched once per frame
//   seg        - active-low cathodes, seg[7] = dp, seg[6:0] = g..a
//   an         - active-low anodes, an[3] leftmost
module score_display
    import pingpong_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sc0,
    input  logic [3:0] sc1,
    output logic [7:0] seg,
    output logic [3:0] an
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [DW-1:0] div;
    idx_t          idx;
    logic [3:0]    l0, l1;
    logic [FW-1:0] fcnt;
    logic          blink;
    logic          slot_end, frame_end, tens, off;
    logic [3:0]    score, digit;
    logic [6:0]    glyph;

    assign slot_end  = div == DW'(SCAN_DIV - 1);
    assign frame_end = slot_end && idx == 2'd3;
    assign score     = idx[1] ? l1 : l0;
    assign tens      = score >= 4'd10;
    assign digit     = idx[0] ? score - (tens ? 4'd10 : 4'd0) : {3'b0, tens};
    assign off       = blink && score == WIN_SCORE;

    // tens slots (idx[0]==0) suppress a leading zero
    seg7_encode u_enc (.digit(digit), .blank(!idx[0] && !tens), .seg(glyph));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div   <= '0;
            idx   <= '0;
            l0    <= '0;
            l1    <= '0;
            fcnt  <= '0;
            blink <= 1'b0;
            seg   <= 8'hFF;
            an    <= 4'hF;
        end else begin
            div <= slot_end ? '0 : div + 1'b1;
            if (slot_end)
                idx <= idx + 1'b1;
            if (frame_end) begin
                l0 <= sc0;
                l1 <= sc1;
                // count only frames that both ended and will start with a winner,
                // so the first winning frame starts the on phase at zero
                if ((sc0 == WIN_SCORE || sc1 == WIN_SCORE) && (l0 == WIN_SCORE || l1 == WIN_SCORE)) begin
                    fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
                    if (fcnt == FW'(BLINK_FRAMES - 1))
                        blink <= ~blink;
                end else begin
                    fcnt  <= '0;
                    blink <= 1'b0;
                end
            end
            // first cycle of every slot keeps all anodes off to avoid ghosting
            an  <= div == '0 ? 4'hF : AN_PAT[idx];
            seg <= off ? 8'hFF : {idx != 2'd1, glyph};
        end
    end
endmodule
